// File: rtl/fpadd_ctrl_pkg.sv
// Shared types and constants for the shared floating-point adder controller.
package fpadd_ctrl_pkg;

  // Controller FSM states
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } ctrl_state_e;

  localparam int unsigned StatusW = 8;
  localparam int unsigned RndW    = 3;

  // Bit positions inside the adder status byte
  localparam int unsigned StatusZero    = 0;
  localparam int unsigned StatusInf     = 1;
  localparam int unsigned StatusInvalid = 2;
  localparam int unsigned StatusTiny    = 3;
  localparam int unsigned StatusHuge    = 4;
  localparam int unsigned StatusInexact = 5;

  // Width of a down-counter that must hold values 0..lat-1 (never zero-width)
  function automatic int unsigned cnt_width(input int unsigned lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/fpadd_share_ctrl_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from the slot
// after the last accepted requester; the pointer only moves on accept.
module rr_arbiter
  import fpadd_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       accept,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       any_req
);

  localparam int unsigned IdW = $clog2(NUM_REQ);

  logic [IdW-1:0] last_q;
  logic [IdW-1:0] id;
  int unsigned    idx;
  logic           found;

  assign any_req = |req;

  // First requesting slot at or after last_q+1, wrapping modulo NUM_REQ
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    id       = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = 32'(last_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      id = IdW'(idx);
      if (!found && req[id]) begin
        found     = 1'b1;
        grant[id] = 1'b1;
        grant_id  = id;
      end
    end
  end

  // Pointer register; reset value makes requester 0 win first
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= IdW'(NUM_REQ - 1);
    end else if (accept) begin
      last_q <= grant_id;
    end
  end

endmodule

// File: rtl/fpadd_share_ctrl.sv
// Shares one combinational FP adder between NUM_REQ requesters. Operands are
// registered and held for ADD_LAT cycles (multicycle path) before the result
// and status are captured and offered on a valid/ready response port.
// Optional feature: define FPADD_CTRL_STICKY_EN to add sticky_clr input and
// an accumulated sticky_status output.
module fpadd_share_ctrl
  import fpadd_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned SIG_WIDTH = 23,
  parameter int unsigned EXP_WIDTH = 8,
  parameter int unsigned ADD_LAT   = 2
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NUM_REQ-1:0]                        req_valid,
  output logic [NUM_REQ-1:0]                        req_ready,
  input  logic [NUM_REQ*(SIG_WIDTH+EXP_WIDTH+1)-1:0] req_a,
  input  logic [NUM_REQ*(SIG_WIDTH+EXP_WIDTH+1)-1:0] req_b,
  input  logic [NUM_REQ*3-1:0]                      req_rnd,
  output logic [SIG_WIDTH+EXP_WIDTH:0]              fpu_a,
  output logic [SIG_WIDTH+EXP_WIDTH:0]              fpu_b,
  output logic [2:0]                                fpu_rnd,
  input  logic [SIG_WIDTH+EXP_WIDTH:0]              fpu_z,
  input  logic [7:0]                                fpu_status,
  output logic                                      resp_valid,
  input  logic                                      resp_ready,
  output logic [SIG_WIDTH+EXP_WIDTH:0]              resp_z,
  output logic [7:0]                                resp_status,
  output logic [$clog2(NUM_REQ)-1:0]                resp_id,
  output logic                                      busy
`ifdef FPADD_CTRL_STICKY_EN
  ,
  input  logic                                      sticky_clr,
  output logic [7:0]                                sticky_status
`endif
);

  localparam int unsigned W    = SIG_WIDTH + EXP_WIDTH + 1;
  localparam int unsigned IdW  = $clog2(NUM_REQ);
  localparam int unsigned CntW = cnt_width(ADD_LAT);

  ctrl_state_e         state_q, state_d;
  logic [CntW-1:0]     cnt_q;
  logic                accept;
  logic                capture;
  logic [NUM_REQ-1:0]  grant;
  logic [IdW-1:0]      grant_id;
  logic                any_req;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (req_valid),
    .accept   (accept),
    .grant    (grant),
    .grant_id (grant_id),
    .any_req  (any_req)
  );

  // Handshakes are suppressed during the reset cycle so nothing is accepted or emitted
  assign req_ready  = (state_q == StIdle && !rst) ? grant : '0;
  assign resp_valid = (state_q == StResp) && !rst;
  assign busy       = (state_q != StIdle);

  // Next-state and strobe decode
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          accept  = 1'b1;
          state_d = StExec;
        end
      end
      StExec: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, settle counter, adder operand and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      fpu_a       <= '0;
      fpu_b       <= '0;
      fpu_rnd     <= '0;
      resp_id     <= '0;
      resp_z      <= '0;
      resp_status <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        fpu_a   <= req_a[grant_id*W +: W];
        fpu_b   <= req_b[grant_id*W +: W];
        fpu_rnd <= req_rnd[grant_id*RndW +: RndW];
        resp_id <= grant_id;
        cnt_q   <= CntW'(ADD_LAT - 1);
      end else if (state_q == StExec && cnt_q != '0) begin
        cnt_q <= cnt_q - CntW'(1);
      end
      // Operands have been stable for ADD_LAT cycles here
      if (capture) begin
        resp_z      <= fpu_z;
        resp_status <= fpu_status;
      end
    end
  end

`ifdef FPADD_CTRL_STICKY_EN
  // Accumulated status flags; a clear coinciding with a capture wins
  always_ff @(posedge clk) begin
    if (rst || sticky_clr) begin
      sticky_status <= '0;
    end else if (capture) begin
      sticky_status <= sticky_status | fpu_status;
    end
  end
`endif

endmodule

// File: tb/tb_fpadd_share_ctrl.sv
// Self-checking bench for fpadd_share_ctrl. Contains a behavioural stand-in
// for the adder that only produces a correct result once its operands have
// been stable for ADD_LAT cycles. Define FPADD_CTRL_STICKY_EN to exercise
// the sticky-status feature.
module tb_fpadd_share_ctrl;

  localparam int NUM_REQ = 4;
  localparam int ADD_LAT = 2;
  localparam int W       = 32;
  localparam int IdW     = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NUM_REQ-1:0]     req_valid, req_ready;
  logic [NUM_REQ*W-1:0]   req_a, req_b;
  logic [NUM_REQ*3-1:0]   req_rnd;
  logic [W-1:0]           fpu_a, fpu_b, fpu_z, resp_z;
  logic [2:0]             fpu_rnd;
  logic [7:0]             fpu_status, resp_status;
  logic                   resp_valid, resp_ready, busy;
  logic [IdW-1:0]         resp_id;
`ifdef FPADD_CTRL_STICKY_EN
  logic                   sticky_clr;
  logic [7:0]             sticky_status;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fpadd_share_ctrl #(
    .NUM_REQ   (NUM_REQ),
    .SIG_WIDTH (23),
    .EXP_WIDTH (8),
    .ADD_LAT   (ADD_LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_rnd     (req_rnd),
    .fpu_a       (fpu_a),
    .fpu_b       (fpu_b),
    .fpu_rnd     (fpu_rnd),
    .fpu_z       (fpu_z),
    .fpu_status  (fpu_status),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_z      (resp_z),
    .resp_status (resp_status),
    .resp_id     (resp_id),
    .busy        (busy)
`ifdef FPADD_CTRL_STICKY_EN
    ,
    .sticky_clr    (sticky_clr),
    .sticky_status (sticky_status)
`endif
  );

  // ---------------- adder stand-in ----------------
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], 11'(32'(f[30:23]) + 32'd896), f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  // Returns {status, z}; truncating add, status[7:6] echo rnd[1:0]
  function automatic logic [39:0] add_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] rnd);
    logic [63:0] d;
    int          fe;
    logic [31:0] z;
    logic [7:0]  st;
    d  = $realtobits(f2r(a) + f2r(b));
    fe = int'(d[62:52]) - 896;
    st = {rnd[1:0], 6'd0};
    if (d[62:52] == 11'd0) begin
      z = {d[63], 31'd0}; st[0] = 1'b1;
    end else if (fe >= 255) begin
      z = {d[63], 8'hFF, 23'd0}; st[1] = 1'b1; st[4] = 1'b1; st[5] = 1'b1;
    end else if (fe <= 0) begin
      z = {d[63], 31'd0}; st[0] = 1'b1; st[3] = 1'b1; st[5] = 1'b1;
    end else begin
      z = {d[63], 8'(fe), d[51:29]}; st[5] = |d[28:0];
    end
    return {st, z};
  endfunction

  int          settle = 0;
  logic [31:0] last_a = '0, last_b = '0;
  logic [39:0] stub;

  always @(negedge clk) begin
    if (fpu_a !== last_a || fpu_b !== last_b) settle <= 1;
    else settle <= settle + 1;
    last_a <= fpu_a;
    last_b <= fpu_b;
  end

  always_comb begin
    stub       = add_model(fpu_a, fpu_b, fpu_rnd);
    fpu_z      = (settle >= ADD_LAT) ? stub[31:0]  : ~stub[31:0];
    fpu_status = (settle >= ADD_LAT) ? stub[39:32] : ~stub[39:32];
  end

  // ---------------- reference helpers ----------------
  function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int last);
    for (int k = 1; k <= NUM_REQ; k++) begin
      int i;
      i = (last + k) % NUM_REQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [31:0] rand_fp();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(110, 145)), 23'($urandom)};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; resp_ready = 1'b0;
`ifdef FPADD_CTRL_STICKY_EN
    sticky_clr = 1'b0;
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '1; resp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== '0) begin
      errors++; $display("FAIL reset_no_handshake req_ready=%b want 0000", req_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({busy, resp_valid, req_ready} !== '0) begin
      errors++; $display("FAIL reset_ctrl busy=%b resp_valid=%b req_ready=%b want 0",
                         busy, resp_valid, req_ready);
    end
    checks++;
    if ({resp_z, resp_status, resp_id} !== '0) begin
      errors++; $display("FAIL reset_resp z=%h st=%h id=%0d want 0", resp_z, resp_status, resp_id);
    end
    checks++;
    if ({fpu_a, fpu_b, fpu_rnd} !== '0) begin
      errors++; $display("FAIL reset_fpu a=%h b=%h rnd=%0d want 0", fpu_a, fpu_b, fpu_rnd);
    end
    rst = 1'b0; req_valid = '0; resp_ready = 1'b0;
  endtask

  task automatic test_single();
    @(negedge clk);
    req_valid = 4'b0001; req_a[0 +: 32] = 32'h3F80_0000; req_b[0 +: 32] = 32'h4000_0000;
    req_rnd[0 +: 3] = 3'd0; resp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL single_ready got %b want 0001", req_ready);
    end
    @(negedge clk);
    req_valid = '0; req_a[0 +: 32] = 32'hDEAD_BEEF;
    #1;
    checks++;
    if ({busy, resp_valid} !== 2'b10) begin
      errors++; $display("FAIL single_c1 busy=%b resp_valid=%b want 1/0", busy, resp_valid);
    end
    for (int c = 1; c <= ADD_LAT; c++) begin
      checks++;
      if (fpu_a !== 32'h3F80_0000 || resp_valid !== 1'b0) begin
        errors++; $display("FAIL operand_stable c%0d fpu_a=%h resp_valid=%b want 3f800000/0",
                           c, fpu_a, resp_valid);
      end
      @(negedge clk);
      #1;
    end
    checks++;
    if ({resp_valid, resp_id, resp_z, resp_status} !== {1'b1, 2'd0, 32'h4040_0000, 8'h00}) begin
      errors++; $display("FAIL single_resp valid=%b id=%0d z=%h st=%h want 1/0/40400000/00",
                         resp_valid, resp_id, resp_z, resp_status);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({busy, resp_valid} !== 2'b00) begin
      errors++; $display("FAIL single_idle busy=%b resp_valid=%b want 0/0", busy, resp_valid);
    end
  endtask

  task automatic test_round_robin();
    int gcount, prev, idx;
    do_reset();
    @(negedge clk);
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[i*W +: W] = rand_fp(); req_b[i*W +: W] = rand_fp(); req_rnd[i*3 +: 3] = 3'd0;
    end
    req_valid = '1; resp_ready = 1'b1;
    gcount = 0; prev = 0;
    for (int cyc = 0; cyc < 40 && gcount < 5; cyc++) begin
      #1;
      if (req_ready !== '0) begin
        idx = -1;
        for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) idx = i;
        checks++;
        if (!$onehot(req_ready) || idx != gcount % NUM_REQ) begin
          errors++; $display("FAIL rr_order grant#%0d got %b want index %0d",
                             gcount, req_ready, gcount % NUM_REQ);
        end
        if (gcount > 0) begin
          checks++;
          if (cyc - prev != ADD_LAT + 2) begin
            errors++; $display("FAIL rr_spacing grant#%0d got %0d cycles want %0d",
                               gcount, cyc - prev, ADD_LAT + 2);
          end
        end
        prev = cyc;
        gcount++;
      end
      @(negedge clk);
    end
    checks++;
    if (gcount != 5) begin
      errors++; $display("FAIL rr_timeout got %0d grants want 5", gcount);
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b;
    logic [2:0]  r;
    logic [39:0] exp;
    int          n;
    do_reset();
    @(negedge clk);
    a = rand_fp(); b = rand_fp(); r = 3'($urandom_range(0, 4)); exp = add_model(a, b, r);
    req_a[64 +: 32] = a; req_b[64 +: 32] = b; req_rnd[6 +: 3] = r;
    req_valid = 4'b0100; resp_ready = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL bp_grant got %b want 0100", req_ready);
    end
    for (n = 1; n <= 10; n++) begin
      @(negedge clk);
      req_valid = '1;
      #1;
      if (resp_valid) break;
    end
    checks++;
    if (n != ADD_LAT + 1) begin
      errors++; $display("FAIL bp_latency resp_valid after %0d cycles want %0d", n, ADD_LAT + 1);
    end
    for (int k = 0; k < 10; k++) begin
      checks++;
      if ({resp_valid, req_ready, resp_id, resp_status, resp_z} !== {1'b1, 4'b0000, 2'd2, exp}) begin
        errors++; $display("FAIL bp_hold k%0d valid=%b rdy=%b id=%0d st=%h z=%h want 1/0000/2/%h/%h",
                           k, resp_valid, req_ready, resp_id, resp_status, resp_z,
                           exp[39:32], exp[31:0]);
      end
      @(negedge clk);
      #1;
    end
    resp_ready = 1'b1;
    #1;
    checks++;
    if ({resp_valid, req_ready} !== {1'b1, 4'b0000}) begin
      errors++; $display("FAIL bp_release valid=%b rdy=%b want 1/0000", resp_valid, req_ready);
    end
    @(negedge clk);
    resp_ready = 1'b0;
    #1;
    checks++;
    if ({busy, resp_valid, req_ready} !== {1'b0, 1'b0, 4'b1000}) begin
      errors++; $display("FAIL bp_after busy=%b valid=%b rdy=%b want 0/0/1000",
                         busy, resp_valid, req_ready);
    end
    req_valid = '0;
  endtask

  task automatic test_reset_mid_exec();
    do_reset();
    @(negedge clk);
    req_a[32 +: 32] = rand_fp(); req_b[32 +: 32] = rand_fp();
    req_valid = 4'b0010; resp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++; $display("FAIL mid_grant got %b want 0010", req_ready);
    end
    @(negedge clk);
    rst = 1'b1; req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({busy, resp_valid} !== 2'b00) begin
      errors++; $display("FAIL mid_abort busy=%b valid=%b want 0/0", busy, resp_valid);
    end
    for (int k = 0; k < ADD_LAT + 2; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if (resp_valid !== 1'b0) begin
        errors++; $display("FAIL mid_no_resp k%0d resp_valid=%b want 0", k, resp_valid);
      end
    end
    @(negedge clk);
    req_valid = '1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL mid_ptr got %b want 0001", req_ready);
    end
    req_valid = '0;
  endtask

  task automatic test_random();
    logic [31:0]        va [NUM_REQ];
    logic [31:0]        vb [NUM_REQ];
    logic [2:0]         vr [NUM_REQ];
    logic [NUM_REQ-1:0] v, granted, exp_ready;
    int                 m_state, m_wait, m_last, w;
    logic [31:0]        acc_a, acc_b;
    logic [2:0]         acc_r;
    logic [IdW-1:0]     acc_id;
    logic [39:0]        acc_res;
    do_reset();
    v = '0; granted = '0; m_state = 0; m_wait = 0; m_last = NUM_REQ - 1;
    acc_a = '0; acc_b = '0; acc_r = '0; acc_id = '0; acc_res = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      va[i] = rand_fp(); vb[i] = rand_fp(); vr[i] = 3'($urandom_range(0, 4));
    end
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (granted[i]) begin
          v[i] = 1'($urandom_range(0, 1));
          va[i] = rand_fp(); vb[i] = rand_fp(); vr[i] = 3'($urandom_range(0, 4));
        end else if (v[i]) begin
          if ($urandom_range(0, 9) == 0) v[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          v[i] = 1'b1;
          va[i] = rand_fp(); vb[i] = rand_fp(); vr[i] = 3'($urandom_range(0, 4));
        end
        req_a[i*W +: W] = va[i]; req_b[i*W +: W] = vb[i]; req_rnd[i*3 +: 3] = vr[i];
      end
      req_valid  = v;
      resp_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_ready = '0; w = -1;
      if (m_state == 0) begin
        w = rr_pick(v, m_last);
        if (w >= 0) exp_ready = NUM_REQ'(1) << w;
      end
      checks++;
      if (req_ready !== exp_ready) begin
        errors++; $display("FAIL rand_ready cyc%0d got %b want %b", cyc, req_ready, exp_ready);
      end
      checks++;
      if ({busy, resp_valid} !== {m_state != 0, m_state == 2}) begin
        errors++; $display("FAIL rand_ctrl cyc%0d busy=%b valid=%b want %b/%b", cyc, busy,
                           resp_valid, m_state != 0, m_state == 2);
      end
      if (m_state == 1) begin
        checks++;
        if ({fpu_a, fpu_b, fpu_rnd} !== {acc_a, acc_b, acc_r}) begin
          errors++; $display("FAIL rand_operand cyc%0d a=%h b=%h rnd=%0d want %h/%h/%0d",
                             cyc, fpu_a, fpu_b, fpu_rnd, acc_a, acc_b, acc_r);
        end
      end
      if (m_state == 2) begin
        checks++;
        if ({resp_id, resp_status, resp_z} !== {acc_id, acc_res}) begin
          errors++; $display("FAIL rand_resp cyc%0d id=%0d st=%h z=%h want %0d/%h/%h", cyc,
                             resp_id, resp_status, resp_z, acc_id, acc_res[39:32], acc_res[31:0]);
        end
      end
      granted = exp_ready;
      case (m_state)
        0: if (w >= 0) begin
          acc_a = va[w]; acc_b = vb[w]; acc_r = vr[w]; acc_id = IdW'(w);
          acc_res = add_model(va[w], vb[w], vr[w]);
          m_last = w; m_wait = ADD_LAT; m_state = 1;
        end
        1: begin
          m_wait--;
          if (m_wait == 0) m_state = 2;
        end
        default: if (resp_ready) m_state = 0;
      endcase
    end
    req_valid = '0;
  endtask

`ifdef FPADD_CTRL_STICKY_EN
  task automatic issue_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    req_valid = 4'b0001; req_a[0 +: 32] = a; req_b[0 +: 32] = b; req_rnd[0 +: 3] = 3'd0;
    resp_ready = 1'b1;
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic test_sticky();
    do_reset();
    issue_op(32'h7F7F_FFFF, 32'h7F7F_FFFF);
    repeat (ADD_LAT + 1) @(negedge clk);
    #1;
    checks++;
    if (sticky_status !== 8'h32) begin
      errors++; $display("FAIL sticky_ovf got %h want 32", sticky_status);
    end
    issue_op(32'h3F80_0000, 32'h4000_0000);
    repeat (ADD_LAT + 1) @(negedge clk);
    #1;
    checks++;
    if (sticky_status !== 8'h32) begin
      errors++; $display("FAIL sticky_keep got %h want 32", sticky_status);
    end
    sticky_clr = 1'b1;
    @(negedge clk);
    sticky_clr = 1'b0;
    #1;
    checks++;
    if (sticky_status !== 8'h00) begin
      errors++; $display("FAIL sticky_clr got %h want 00", sticky_status);
    end
    issue_op(32'h7F7F_FFFF, 32'h7F7F_FFFF);
    repeat (ADD_LAT - 1) @(negedge clk);
    sticky_clr = 1'b1;
    @(negedge clk);
    sticky_clr = 1'b0;
    #1;
    checks++;
    if (sticky_status !== 8'h00) begin
      errors++; $display("FAIL sticky_clr_wins got %h want 00", sticky_status);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_rnd = '0; resp_ready = 1'b0;
`ifdef FPADD_CTRL_STICKY_EN
    sticky_clr = 1'b0;
`endif
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_mid_exec();
    test_random();
`ifdef FPADD_CTRL_STICKY_EN
    test_sticky();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
